// File: rtl/select_pkg.sv
// Shared types and default sizes for the registered select/demux lane bank.
package select_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sel_state_e;

  localparam int SEL_DATA_W_DEFAULT   = 2;
  localparam int SEL_CHANNELS_DEFAULT = 16;

endpackage

// File: rtl/select_lane_reg.sv
// One stored lane: async active-low reset, load enable and synchronous clear.
module select_lane_reg #(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // NOTE: every lane is a reset flop because the bus feeds consumers directly;
  // clear takes priority so a sweep can never be undone by a stray load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     q <= '0;
    else if (clear)  q <= '0;
    else if (load)   q <= d;
  end

endmodule

// File: rtl/select_demux_bank.sv
// Registered 1-to-CHANNELS write demux with clear sweep and readback.
// Optional SELECT_WRITE_ONCE_EN: occupied (nonzero) lanes reject further writes.
module select_demux_bank
  import select_pkg::*;
#(
  parameter  int DATA_W   = SEL_DATA_W_DEFAULT,
  parameter  int CHANNELS = SEL_CHANNELS_DEFAULT,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ack,
  output logic                       wr_rej,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       clr_done,
  input  logic [SEL_W-1:0]           rd_sel,
  output logic [DATA_W-1:0]          rd_data,
  output logic [CHANNELS*DATA_W-1:0] out
);

  sel_state_e          state, state_next;
  logic [SEL_W-1:0]    clr_idx;
  logic [DATA_W-1:0]   lane_q [CHANNELS];
  logic [CHANNELS-1:0] lane_load, lane_clear;
  logic                accept, in_range, occupied, store, last_lane;
  logic                ack_d, rej_d, done_d;

  assign in_range  = int'(wr_sel) < CHANNELS;
  assign last_lane = (clr_idx == SEL_W'(CHANNELS - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_req)   state_next = CLEAR;
      CLEAR:   if (last_lane) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: each signal gets a default before any branch so no latch is inferred.
  always_comb begin
    wr_ready = (state == IDLE) && !clr_req;
    accept   = wr_valid && wr_ready;
    occupied = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (wr_sel == SEL_W'(i)) occupied = |lane_q[i];
`ifdef SELECT_WRITE_ONCE_EN
    store = accept && in_range && !occupied;
`else
    store = accept && in_range;
`endif
    ack_d  = store;
    rej_d  = accept && !store;
    done_d = (state == CLEAR) && last_lane;
    for (int i = 0; i < CHANNELS; i++) begin
      lane_load[i]  = store && (wr_sel == SEL_W'(i));
      lane_clear[i] = (state == CLEAR) && (clr_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_idx  <= '0;
      busy     <= 1'b0;
      wr_ack   <= 1'b0;
      wr_rej   <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      if (state == CLEAR && !last_lane) clr_idx <= clr_idx + SEL_W'(1);
      else                              clr_idx <= '0;
      busy     <= (state_next == CLEAR);
      wr_ack   <= ack_d;
      wr_rej   <= rej_d;
      clr_done <= done_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    select_lane_reg #(.DATA_W(DATA_W)) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .load   (lane_load[i]),
      .clear  (lane_clear[i]),
      .d      (wr_data),
      .q      (lane_q[i])
    );
    assign out[i*DATA_W +: DATA_W] = lane_q[i];
  end

  // Out-of-range selects (non power-of-two CHANNELS) read back as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (rd_sel == SEL_W'(i)) rd_data = lane_q[i];
  end

endmodule

// File: tb/tb_select_demux_bank.sv
// Self-checking bench: 16- and 10-lane instances share stimulus, each checked
// against a lane-array model that tracks remaining sweep lanes as a count.
module tb_select_demux_bank;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_sel = '0;
  logic [1:0] wr_data = '0;
  logic       clr_req = 1'b0;
  logic [3:0] rd_sel = '0;

  logic        ready_a, ack_a, rej_a, busy_a, done_a;
  logic [1:0]  rdd_a;
  logic [31:0] out_a;
  logic        ready_b, ack_b, rej_b, busy_b, done_b;
  logic [1:0]  rdd_b;
  logic [19:0] out_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  select_demux_bank #(.DATA_W(2), .CHANNELS(16)) dut16 (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(ready_a),
    .wr_sel(wr_sel), .wr_data(wr_data), .wr_ack(ack_a), .wr_rej(rej_a),
    .clr_req(clr_req), .busy(busy_a), .clr_done(done_a),
    .rd_sel(rd_sel), .rd_data(rdd_a), .out(out_a)
  );

  select_demux_bank #(.DATA_W(2), .CHANNELS(10)) dut10 (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(ready_b),
    .wr_sel(wr_sel), .wr_data(wr_data), .wr_ack(ack_b), .wr_rej(rej_b),
    .clr_req(clr_req), .busy(busy_b), .clr_done(done_b),
    .rd_sel(rd_sel), .rd_data(rdd_b), .out(out_b)
  );

  // Reference model: index 0 = 16 lanes, index 1 = 10 lanes.
  int       nch [2] = '{16, 10};
  bit [1:0] m_lane [2][16];
  int       m_left [2];
  bit       m_ack [2], m_rej [2], m_done [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_out(input int k);
    logic [63:0] r = '0;
    for (int i = 0; i < nch[k]; i++) r[i*2 +: 2] = m_lane[k][i];
    return r;
  endfunction

  function automatic logic [1:0] m_rd(input int k, input int sel);
    return (sel < nch[k]) ? m_lane[k][sel] : 2'b00;
  endfunction

  function automatic bit m_ready(input int k);
    return (m_left[k] == 0) && !clr_req;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_lane[k][i] = 2'b00;
      m_left[k] = 0; m_ack[k] = 0; m_rej[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_ack[k] = 0; m_rej[k] = 0; m_done[k] = 0;
      if (m_left[k] > 0) begin
        m_lane[k][nch[k] - m_left[k]] = 2'b00;
        m_left[k]--;
        if (m_left[k] == 0) m_done[k] = 1;
      end else if (clr_req) begin
        m_left[k] = nch[k];
      end else if (wr_valid) begin
        bit ok = int'(wr_sel) < nch[k];
`ifdef SELECT_WRITE_ONCE_EN
        if (ok && m_lane[k][wr_sel] != 2'b00) ok = 0;
`endif
        if (ok) begin
          m_lane[k][wr_sel] = wr_data;
          m_ack[k] = 1;
        end else m_rej[k] = 1;
      end
    end
  endtask

  task automatic check_regs();
    check("ack16", ack_a, m_ack[0]);   check("ack10", ack_b, m_ack[1]);
    check("rej16", rej_a, m_rej[0]);   check("rej10", rej_b, m_rej[1]);
    check("busy16", busy_a, m_left[0] > 0); check("busy10", busy_b, m_left[1] > 0);
    check("done16", done_a, m_done[0]); check("done10", done_b, m_done[1]);
    check("out16", out_a, m_out(0));   check("out10", out_b, m_out(1));
    check("rd16", rdd_a, m_rd(0, rd_sel)); check("rd10", rdd_b, m_rd(1, rd_sel));
  endtask

  // One clock: drive at the falling edge, check combinational outputs, take the
  // rising edge, then check registered outputs at the next falling edge.
  task automatic cyc(input bit v, input int s, input int d, input bit c, input int r);
    wr_valid = v; wr_sel = 4'(s); wr_data = 2'(d); clr_req = c; rd_sel = 4'(r);
    #1;
    check("ready16", ready_a, m_ready(0)); check("ready10", ready_b, m_ready(1));
    check("rdpre16", rdd_a, m_rd(0, r));   check("rdpre10", rdd_b, m_rd(1, r));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_regs();
  endtask

  int busy_cycles;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out16", out_a, 64'h0); check("rst_busy16", busy_a, 1'b0);
    check("rst_ack16", ack_a, 1'b0);  check("rst_done10", done_b, 1'b0);
    resetn = 1'b1;

    // Single write to lane 5, then readback.
    cyc(1, 5, 2, 0, 5);
    check("lane5_out", out_a, 64'h800);
    check("lane5_ack", ack_a, 1'b1);
    cyc(0, 0, 0, 0, 5);
    check("lane5_ack_fall", ack_a, 1'b0);

    // Out-of-range for the 10-lane instance, legal for the 16-lane one.
    cyc(1, 12, 1, 0, 12);
    check("oor_rej10", rej_b, 1'b1); check("oor_ack10", ack_b, 1'b0);
    check("oor_rd10", rdd_b, 2'b00);
    cyc(0, 0, 0, 0, 0);

    // Fill every lane, then sweep and count busy cycles.
    for (int i = 0; i < 16; i++) cyc(1, i, 3, 0, i);
    cyc(0, 0, 0, 1, 0);
    busy_cycles = 1;
    for (int t = 0; t < 40 && busy_a === 1'b1; t++) begin
      cyc(1, 7, 1, 0, 7);
      if (busy_a === 1'b1) busy_cycles++;
    end
    check("sweep_len16", busy_cycles, 16);
    check("sweep_out16", out_a, 64'h0);
    cyc(0, 0, 0, 0, 0);

    // Clear and write in the same cycle: write held until sweep ends.
    cyc(1, 3, 1, 1, 3);
    check("held_lane3", out_a[7:6], 2'b00);
    for (int t = 0; t < 40 && m_left[0] > 0; t++) cyc(1, 3, 1, 0, 3);
    cyc(1, 3, 1, 0, 3);
    check("held_acc", out_a[7:6], 2'b01);
    cyc(0, 0, 0, 0, 0);

    // Reset in the middle of a sweep.
    for (int i = 8; i < 16; i++) cyc(1, i, 2, 0, i);
    cyc(0, 0, 0, 1, 0);
    repeat (7) cyc(0, 0, 0, 0, 9);
    resetn = 1'b0;
    #1;
    model_reset();
    check("mid_rst_out16", out_a, 64'h0); check("mid_rst_out10", out_b, 64'h0);
    check("mid_rst_busy", busy_a, 1'b0);
    @(posedge clk); @(negedge clk);
    check("mid_rst_done", done_a, 1'b0);
    resetn = 1'b1;
    cyc(1, 0, 3, 0, 0);
    check("post_rst_ack", ack_a, 1'b1);
    cyc(0, 0, 0, 0, 0);
    check("post_rst_done", done_a, 1'b0);

    // Overwrite lane 2; outcome depends on the write-once build.
    cyc(1, 2, 1, 0, 2);
    cyc(1, 2, 2, 0, 2);
`ifdef SELECT_WRITE_ONCE_EN
    check("wo_rej", rej_a, 1'b1); check("wo_lane2", out_a[5:4], 2'b01);
`else
    check("ow_ack", ack_a, 1'b1); check("ow_lane2", out_a[5:4], 2'b10);
`endif
    cyc(0, 0, 0, 0, 0);

    // Random traffic.
    for (int t = 0; t < 400; t++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 3),
          $urandom_range(0, 31) == 0, $urandom_range(0, 15));
    repeat (20) cyc(0, 0, 0, 0, $urandom_range(0, 15));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
